// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART bootloader.
//   loader_state_e : command FSM states
//   CMD_*          : command opcodes received as the first byte of a command
//   ACK / NAK      : single-byte status replies
package uart_loader_pkg;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        DATA,
        REQ,
        WAIT,
        RESP
    } loader_state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

endpackage

// File: rtl/uart_loader_if.sv
// Handshake bundle between the loader, the UART byte streams and the bus host port.
//   rx_*   : received byte stream (valid/ready), loader is the sink
//   tx_*   : response byte stream (valid/ready), loader is the source
//   host_* : single-word bus port, loader issues requests
// modport master : loader side
// modport slave  : UART / bus environment side
interface uart_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        host_req;
    logic [31:0] host_addr;
    logic        host_we;
    logic [3:0]  host_be;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, host_gnt, host_rvalid, host_rdata,
        output rx_ready, tx_valid, tx_data, host_req, host_addr, host_we, host_be, host_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, host_gnt, host_rvalid, host_rdata,
        input  rx_ready, tx_valid, tx_data, host_req, host_addr, host_we, host_be, host_wdata
    );
endinterface

// File: rtl/uart_loader_timer.sv
// Loadable down-counter used for both the inter-byte and the bus timeouts.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : reload counter with load_val_i (has priority over en_i)
//   load_val_i    : reload value; expiry fires load_val_i+1 enabled cycles later
//   en_i          : count down while high
//   expired_o     : counter is at zero while enabled
module uart_loader_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);
    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/uart_loader.sv
// Byte-protocol bootloader between a UART and a single-word bus host port.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : rx/tx byte streams and bus host port (master side)
//   core_hold_o   : 1 keeps the core in reset until a GO command is seen
// Commands (fields little-endian): W A0..A3 D0..D3 -> ACK, R A0..A3 -> D0..D3,
// G -> ACK and release core, anything else -> NAK.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ByteTimeout = 100_000,
    parameter int unsigned BusTimeout  = 1_024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    uart_loader_if.master bus,
    output logic          core_hold_o
);
    localparam int unsigned MaxTimeout = (ByteTimeout > BusTimeout) ? ByteTimeout : BusTimeout;
    localparam int unsigned TW         = $clog2(MaxTimeout + 1);

    loader_state_e state_q;
    logic [1:0]    idx_q;
    logic [31:0]   addr_q, wdata_q;
    logic [23:0]   rsh_q;      // remaining read-data bytes still to send
    logic [1:0]    rcnt_q;     // bytes left after the one on tx_data
    logic          we_q, req_q, tx_valid_q;
    logic [7:0]    tx_data_q;

    logic          rx_ready, rx_fire, tx_fire, last_byte, to_req;
    logic          tmr_en, tmr_exp;
    logic [TW-1:0] tmr_val;

    assign rx_ready  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign rx_fire   = bus.rx_valid && rx_ready;
    assign tx_fire   = tx_valid_q && bus.tx_ready;
    assign last_byte = (idx_q == 2'd3);
    assign to_req    = rx_fire && last_byte &&
                       ((state_q == ADDR && !we_q) || state_q == DATA);

    // Single timer: every consumed byte reloads it; the byte that moves us into
    // REQ reloads it with the bus budget instead.
    assign tmr_val = to_req ? TW'(BusTimeout - 1) : TW'(ByteTimeout - 1);
    assign tmr_en  = (state_q == ADDR) || (state_q == DATA) ||
                     (state_q == REQ)  || (state_q == WAIT);

    uart_loader_timer #(.Width(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (rx_fire),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_exp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CMD;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsh_q       <= '0;
            rcnt_q      <= '0;
            we_q        <= 1'b0;
            req_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            core_hold_o <= 1'b1;
        end else begin
            case (state_q)
                CMD: if (rx_fire) begin
                    idx_q  <= '0;
                    rcnt_q <= '0;
                    case (bus.rx_data)
                        CMD_WRITE: begin we_q <= 1'b1; state_q <= ADDR; end
                        CMD_READ:  begin we_q <= 1'b0; state_q <= ADDR; end
                        CMD_GO: begin
                            core_hold_o <= 1'b0;
                            tx_valid_q  <= 1'b1;
                            tx_data_q   <= ACK;
                            state_q     <= RESP;
                        end
                        default: begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= NAK;
                            state_q    <= RESP;
                        end
                    endcase
                end
                ADDR: if (rx_fire) begin
                    addr_q[8*idx_q +: 8] <= bus.rx_data;
                    idx_q <= idx_q + 1'b1;
                    if (last_byte) begin
                        state_q <= we_q ? DATA : REQ;
                        req_q   <= !we_q;
                    end
                end else if (tmr_exp) begin
                    addr_q     <= '0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= NAK;
                    rcnt_q     <= '0;
                    state_q    <= RESP;
                end
                DATA: if (rx_fire) begin
                    wdata_q[8*idx_q +: 8] <= bus.rx_data;
                    idx_q <= idx_q + 1'b1;
                    if (last_byte) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end else if (tmr_exp) begin
                    addr_q     <= '0;
                    wdata_q    <= '0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= NAK;
                    rcnt_q     <= '0;
                    state_q    <= RESP;
                end
                REQ: if (bus.host_gnt) begin
                    req_q   <= 1'b0;
                    state_q <= WAIT;
                end else if (tmr_exp) begin
                    req_q      <= 1'b0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= NAK;
                    rcnt_q     <= '0;
                    state_q    <= RESP;
                end
                WAIT: if (bus.host_rvalid) begin
                    tx_valid_q <= 1'b1;
                    state_q    <= RESP;
                    if (we_q) begin
                        tx_data_q <= ACK;
                        rcnt_q    <= '0;
                    end else begin
                        tx_data_q <= bus.host_rdata[7:0];
                        rsh_q     <= bus.host_rdata[31:8];
                        rcnt_q    <= 2'd3;
                    end
                end else if (tmr_exp) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= NAK;
                    rcnt_q     <= '0;
                    state_q    <= RESP;
                end
                RESP: if (tx_fire) begin
                    if (rcnt_q == '0) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= CMD;
                    end else begin
                        tx_data_q <= rsh_q[7:0];
                        rsh_q     <= {8'h00, rsh_q[23:8]};
                        rcnt_q    <= rcnt_q - 1'b1;
                    end
                end
                default: state_q <= CMD;
            endcase
        end
    end

    assign bus.rx_ready   = rx_ready;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.host_req   = req_q;
    assign bus.host_addr  = {addr_q[31:2], 2'b00};
    assign bus.host_we    = we_q;
    assign bus.host_be    = 4'hF;
    assign bus.host_wdata = wdata_q;
endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: stimulus pushes expected tx bytes and bus
// transactions into queues; monitors pop and compare as the DUT presents them.
module tb_uart_loader;
    import uart_loader_pkg::*;

    localparam int unsigned BT = 20;   // byte timeout
    localparam int unsigned UT = 16;   // bus timeout

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    logic clk, rst_n, core_hold;
    int   errors = 0, checks = 0;
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];
    logic       gnt_en = 1'b1, rnd_ready = 1'b0, pend = 1'b0;
    logic [31:0] rd_word = '0;

    uart_loader_if bus ();

    uart_loader #(.ByteTimeout(BT), .BusTimeout(UT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .core_hold_o (core_hold)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // tx_ready driver
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // bus responder: grant one cycle after req, rvalid the cycle after grant
    initial begin
        bus.host_gnt = 0; bus.host_rvalid = 0; bus.host_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.host_rvalid = pend;
            bus.host_rdata  = rd_word;
            pend = 1'b0;
            bus.host_gnt = bus.host_req && gnt_en && !bus.host_gnt && rst_n;
            if (bus.host_gnt) pend = 1'b1;
        end
    end

    // monitors
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("tx_valid_held", 32'(bus.tx_valid), 32'd1);
                    chk("tx_data_stable", 32'(bus.tx_data), 32'(hold_d));
                end
                hold_v = bus.tx_valid && !bus.tx_ready;
                hold_d = bus.tx_data;
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
                    else chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
                end
                if (bus.host_req && bus.host_gnt) begin
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected", bus.host_addr, 32'hFFFF_FFFF);
                    end else begin
                        bus_t e;
                        e = exp_bus.pop_front();
                        chk("bus_addr", bus.host_addr, e.addr);
                        chk("bus_we", 32'(bus.host_we), 32'(e.we));
                        chk("bus_be", 32'(bus.host_be), 32'hF);
                        if (e.we) chk("bus_wdata", bus.host_wdata, e.wdata);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        do begin @(negedge clk); n++; end while (!bus.rx_ready && n < 500);
        if (!bus.rx_ready) chk("rx_accept_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || bus.tx_valid) && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) begin
            chk("drain_timeout", 32'(n), 32'd0);
            exp_tx.delete();
            exp_bus.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        chk({tag, "_host_req"}, 32'(bus.host_req), 32'd0);
        chk({tag, "_host_we"}, 32'(bus.host_we), 32'd0);
        chk({tag, "_host_addr"}, bus.host_addr, 32'd0);
        chk({tag, "_host_wdata"}, bus.host_wdata, 32'd0);
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    endtask

    initial begin
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // write 0xDEADBEEF to 0x10
        exp_bus.push_back('{32'h10, 1'b1, 32'hDEAD_BEEF});
        exp_tx.push_back(ACK);
        send_byte(CMD_WRITE); send_word(32'h10); send_word(32'hDEAD_BEEF);
        drain();

        // read 0x10 with random tx backpressure
        rnd_ready = 1'b1;
        rd_word = 32'h1234_5678;
        exp_bus.push_back('{32'h10, 1'b0, 32'h0});
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        send_byte(CMD_READ); send_word(32'h10);
        drain();

        // unaligned read address is masked
        rd_word = 32'hA5C3_0F96;
        exp_bus.push_back('{32'h10, 1'b0, 32'h0});
        exp_tx.push_back(8'h96); exp_tx.push_back(8'h0F);
        exp_tx.push_back(8'hC3); exp_tx.push_back(8'hA5);
        send_byte(CMD_READ); send_word(32'h13);
        drain();
        rnd_ready = 1'b0;

        // unknown command
        exp_tx.push_back(NAK);
        send_byte(8'h41);
        drain();

        // byte timeout mid-address
        exp_tx.push_back(NAK);
        send_byte(CMD_WRITE); send_byte(8'h10);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx_valid) break;
            n++;
        end
        chk("byte_timeout_cycles", 32'(n), 32'(BT));
        drain();

        // GO releases the core; repeat GO is still ACKed
        chk("hold_before_go", 32'(core_hold), 32'd1);
        exp_tx.push_back(ACK);
        send_byte(CMD_GO);
        chk("hold_after_go", 32'(core_hold), 32'd0);
        drain();
        exp_tx.push_back(ACK);
        send_byte(CMD_GO);
        drain();
        chk("hold_after_go2", 32'(core_hold), 32'd0);

        // bus timeout: no grant
        gnt_en = 1'b0;
        exp_tx.push_back(NAK);
        send_byte(CMD_READ); send_word(32'h20);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.host_req) break;
            n++;
        end
        chk("bus_timeout_cycles", 32'(n), 32'(UT));
        drain();
        gnt_en = 1'b1;

        // reset mid-DATA
        send_byte(CMD_WRITE); send_word(32'h44); send_byte(8'hAA);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // normal operation after reset
        exp_bus.push_back('{32'h4, 1'b1, 32'h0403_0201});
        exp_tx.push_back(ACK);
        send_byte(CMD_WRITE); send_word(32'h4); send_word(32'h0403_0201);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
